lc3_mem_ctrl: RTL

//  CPU-side initiator for the 128x16 LC-3 main memory: takes MAR/MDR read/write requests from the datapath.

---
 rtl/lc3_mem_ctrl_if.sv | 24 ++
 rtl/lc3_mem_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/lc3_mem_ctrl_if.sv
// CPU-side request/response bundle between the LC-3 datapath (master) and
// the memory access controller (slave).
interface lc3_mem_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              req_rd;
  logic              req_wr;
  logic [15:0]       mar;
  logic [DATA_W-1:0] mdr_in;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req_rd, req_wr, mar, mdr_in,
    input  busy, done, err, rdata
  );

  modport slave (
    input  req_rd, req_wr, mar, mdr_in,
    output busy, done, err, rdata
  );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 main-memory initiator: one-cycle re/we pulses, ready wait with watchdog,
// address range check, and a single-cycle done/err completion to the control FSM.
module lc3_mem_ctrl #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT     = 15,
  parameter int CHECK_RANGE = 1
) (
  input  logic              clk,
  input  logic              rst,
  lc3_mem_ctrl_if.slave     cpu,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0] mem_d_o,
  input  logic [DATA_W-1:0] mem_q_i,
  input  logic              mem_ready_i
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_IDLE   = 3'd1,
    S_ISSUE  = 3'd2,
    S_SETTLE = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e            state_q;
  logic [1:0]        holdoff_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_rd_q;
  logic              mem_re_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_raddr_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [DATA_W-1:0] mem_d_q;
  logic              done_q;
  logic              err_q;
  logic              busy_q;
  logic [DATA_W-1:0] rdata_q;
  logic              range_bad_s;

  assign range_bad_s = (CHECK_RANGE != 0) && (cpu.mar[15:ADDR_W] != {(16-ADDR_W){1'b0}});

  // Access sequencer: every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HOLD;
      holdoff_q   <= 2'd2;
      cnt_q       <= '0;
      is_rd_q     <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_d_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_HOLD: begin
          if (holdoff_q == 2'd1) begin
            state_q <= S_IDLE;
          end else begin
            holdoff_q <= holdoff_q - 2'd1;
          end
        end
        S_IDLE: begin
          if (cpu.req_rd && cpu.req_wr) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            busy_q  <= 1'b1;
          end else if (cpu.req_rd ^ cpu.req_wr) begin
            mem_raddr_q <= cpu.mar[ADDR_W-1:0];
            mem_waddr_q <= cpu.mar[ADDR_W-1:0];
            mem_d_q     <= cpu.mdr_in;
            is_rd_q     <= cpu.req_rd;
            busy_q      <= 1'b1;
            if (range_bad_s) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q  <= S_ISSUE;
              mem_re_q <= cpu.req_rd;
              mem_we_q <= cpu.req_wr;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= is_rd_q ? S_SETTLE : S_WAIT;
        end
        // A ready left over from an earlier access may still be visible here.
        S_SETTLE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_ready_i) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            if (is_rd_q) begin
              rdata_q <= mem_q_i;
            end else begin
              rdata_q <= rdata_q;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_HOLD;
          holdoff_q <= 2'd2;
          busy_q    <= 1'b0;
          err_q     <= 1'b0;
        end
      endcase
    end
  end

  assign mem_re_o    = mem_re_q;
  assign mem_we_o    = mem_we_q;
  assign mem_raddr_o = mem_raddr_q;
  assign mem_waddr_o = mem_waddr_q;
  assign mem_d_o     = mem_d_q;
  assign cpu.busy    = busy_q;
  assign cpu.done    = done_q;
  assign cpu.err     = err_q;
  assign cpu.rdata   = rdata_q;

endmodule
